// File: rtl/pol_ofm_wr_if.sv
// rtl/pol_ofm_wr_if.sv - CCU config, pooled-vector stream and GLB write bus of the pooling output writer
interface pol_ofm_wr_if #(
  parameter int ACT_WIDTH      = 8,
  parameter int POOL_COMP_CORE = 64,
  parameter int SRAM_WIDTH     = 256,
  parameter int IDX_WIDTH      = 10,
  parameter int ADDR_WIDTH     = 16
);
  logic                                CCUOWR_Rst;
  logic                                CCUOWR_CfgVld;
  logic                                OWRCCU_CfgRdy;
  logic [IDX_WIDTH-1:0]                CCUOWR_CfgNip;
  logic [ADDR_WIDTH-1:0]               CCUOWR_CfgBaseAddr;
  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] POLOWR_Ofm;
  logic                                POLOWR_OfmVld;
  logic                                OWRPOL_OfmRdy;
  logic                                OWRGLB_WrVld;
  logic [ADDR_WIDTH-1:0]               OWRGLB_WrAddr;
  logic [SRAM_WIDTH-1:0]               OWRGLB_WrDat;
  logic                                GLBOWR_WrRdy;
  logic                                OWRCCU_Done;

  modport slave (
    input  CCUOWR_Rst, CCUOWR_CfgVld, CCUOWR_CfgNip, CCUOWR_CfgBaseAddr,
    input  POLOWR_Ofm, POLOWR_OfmVld, GLBOWR_WrRdy,
    output OWRCCU_CfgRdy, OWRPOL_OfmRdy, OWRGLB_WrVld, OWRGLB_WrAddr,
    output OWRGLB_WrDat, OWRCCU_Done
  );

  modport master (
    output CCUOWR_Rst, CCUOWR_CfgVld, CCUOWR_CfgNip, CCUOWR_CfgBaseAddr,
    output POLOWR_Ofm, POLOWR_OfmVld, GLBOWR_WrRdy,
    input  OWRCCU_CfgRdy, OWRPOL_OfmRdy, OWRGLB_WrVld, OWRGLB_WrAddr,
    input  OWRGLB_WrDat, OWRCCU_Done
  );
endinterface

// File: rtl/pol_ofm_wr.sv
// rtl/pol_ofm_wr.sv - pooling output writer: slices pooled vectors into GLB words at consecutive addresses
module pol_ofm_wr #(
  parameter int ACT_WIDTH      = 8,
  parameter int POOL_COMP_CORE = 64,
  parameter int SRAM_WIDTH     = 256,
  parameter int IDX_WIDTH      = 10,
  parameter int ADDR_WIDTH     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  pol_ofm_wr_if.slave bus
);
  localparam int VEC_WIDTH = ACT_WIDTH * POOL_COMP_CORE;
  localparam int BEATS     = VEC_WIDTH / SRAM_WIDTH;
  localparam int SLC_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RECV, SEND, DONE} state_t;

  state_t                 state, stateNxt;
  logic [IDX_WIDTH-1:0]   nip;
  logic [IDX_WIDTH-1:0]   cntPnt;
  logic [SLC_WIDTH-1:0]   cntSlc;
  logic [ADDR_WIDTH-1:0]  baseAddr;
  logic [VEC_WIDTH-1:0]   ofmBuf;
  logic [IDX_WIDTH:0]     pntInc;
  logic                   lastSlc;
  logic                   lastPnt;
  logic                   wrHs;
  logic                   ofmRdy;
  logic                   ofmHs;

  assign pntInc  = {1'b0, cntPnt} + {{IDX_WIDTH{1'b0}}, 1'b1};
  assign lastSlc = (cntSlc == SLC_WIDTH'(BEATS - 1));
  assign lastPnt = (pntInc == {1'b0, nip});
  assign wrHs    = (state == SEND) && bus.GLBOWR_WrRdy;
  // A new vector may enter on the very cycle the last slice leaves, so SEND streams without bubbles.
  assign ofmRdy  = (state == RECV) || (wrHs && lastSlc && !lastPnt);
  assign ofmHs   = ofmRdy && bus.POLOWR_OfmVld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: begin
        if (bus.CCUOWR_CfgVld) begin
          stateNxt = (bus.CCUOWR_CfgNip == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (bus.POLOWR_OfmVld) begin
          stateNxt = SEND;
        end
      end
      SEND: begin
        if (wrHs && lastSlc) begin
          if (lastPnt) begin
            stateNxt = DONE;
          end else if (ofmHs) begin
            stateNxt = SEND;
          end else begin
            stateNxt = RECV;
          end
        end
      end
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
    if (bus.CCUOWR_Rst) begin
      stateNxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nip      <= '0;
      baseAddr <= '0;
      cntPnt   <= '0;
      cntSlc   <= '0;
      ofmBuf   <= '0;
    end else if (bus.CCUOWR_Rst) begin
      cntPnt <= '0;
      cntSlc <= '0;
    end else begin
      if (state == IDLE && bus.CCUOWR_CfgVld) begin
        nip      <= bus.CCUOWR_CfgNip;
        baseAddr <= bus.CCUOWR_CfgBaseAddr;
        cntPnt   <= '0;
        cntSlc   <= '0;
      end
      if (ofmHs) begin
        ofmBuf <= bus.POLOWR_Ofm;
      end
      if (wrHs) begin
        if (lastSlc) begin
          cntSlc <= '0;
          cntPnt <= cntPnt + 1'b1;
        end else begin
          cntSlc <= cntSlc + 1'b1;
        end
      end
    end
  end

  assign bus.OWRCCU_CfgRdy = (state == IDLE);
  assign bus.OWRPOL_OfmRdy = ofmRdy;
  assign bus.OWRGLB_WrVld  = (state == SEND);
  // Address arithmetic is kept at ADDR_WIDTH so the write window wraps around the top of the GLB.
  assign bus.OWRGLB_WrAddr = baseAddr + ADDR_WIDTH'(cntPnt) * ADDR_WIDTH'(BEATS) + ADDR_WIDTH'(cntSlc);
  assign bus.OWRGLB_WrDat  = ofmBuf[int'(cntSlc)*SRAM_WIDTH +: SRAM_WIDTH];
  assign bus.OWRCCU_Done   = (state == DONE);
endmodule

// File: tb/tb_pol_ofm_wr.sv
// tb/tb_pol_ofm_wr.sv - directed self-checking bench for pol_ofm_wr
module tb_pol_ofm_wr;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pol_ofm_wr_if bus ();
  pol_ofm_wr dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [511:0] vecs [8];
  logic [15:0]  wAddr [$];
  logic [255:0] wDat [$];
  int           wCyc [$];
  int           rdyCyc [$];
  int           doneCyc, doneCnt, stallBad, pendBad;
  logic         cfgRdyAfter, lastCfgRdy;

  function automatic logic [511:0] mkVec(input int i);
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = {8'(i), 8'(k), 16'hC0DE};
    return v;
  endfunction

  // Configures one job, then streams vectors and records everything the GLB/CCU side sees.
  task automatic run(input logic [9:0] nip, input logic [15:0] base, input int nvec, input int vecOff,
                     input logic [3:0] pat, input int rstCyc, input int maxCyc);
    int cyc, vi;
    logic prevStall;
    logic [15:0] pA;
    logic [255:0] pD;
    wAddr.delete(); wDat.delete(); wCyc.delete(); rdyCyc.delete();
    doneCyc = -1; doneCnt = 0; stallBad = 0; pendBad = 0; cfgRdyAfter = 1'b0; prevStall = 1'b0;
    pA = '0; pD = '0;
    @(posedge clk); #1;
    bus.CCUOWR_CfgVld = 1'b1; bus.CCUOWR_CfgNip = nip; bus.CCUOWR_CfgBaseAddr = base;
    @(posedge clk); #1;
    bus.CCUOWR_CfgVld = 1'b0;
    cyc = 0; vi = 0;
    while (cyc < maxCyc) begin
      bus.POLOWR_OfmVld = (vi < nvec);
      bus.POLOWR_Ofm    = vecs[(vi + vecOff) % 8];
      bus.GLBOWR_WrRdy  = pat[cyc % 4];
      bus.CCUOWR_Rst    = (cyc == rstCyc);
      @(negedge clk);
      if (prevStall && bus.OWRGLB_WrVld && (bus.OWRGLB_WrAddr !== pA || bus.OWRGLB_WrDat !== pD)) stallBad++;
      prevStall = bus.OWRGLB_WrVld && !bus.GLBOWR_WrRdy;
      pA = bus.OWRGLB_WrAddr; pD = bus.OWRGLB_WrDat;
      if (bus.OWRPOL_OfmRdy && bus.OWRGLB_WrVld && !(bus.GLBOWR_WrRdy && (wAddr.size() % 2 == 1))) pendBad++;
      if (bus.OWRGLB_WrVld && bus.GLBOWR_WrRdy) begin
        wAddr.push_back(bus.OWRGLB_WrAddr); wDat.push_back(bus.OWRGLB_WrDat); wCyc.push_back(cyc);
      end
      if (bus.OWRPOL_OfmRdy) begin
        rdyCyc.push_back(cyc);
        if (bus.POLOWR_OfmVld) vi++;
      end
      if (bus.OWRCCU_Done) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = cyc;
      end
      lastCfgRdy = bus.OWRCCU_CfgRdy;
      if (doneCyc >= 0 && cyc == doneCyc + 1) begin
        cfgRdyAfter = bus.OWRCCU_CfgRdy;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.POLOWR_OfmVld = 1'b0; bus.CCUOWR_Rst = 1'b0; bus.GLBOWR_WrRdy = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.CCUOWR_Rst = 1'b0; bus.CCUOWR_CfgVld = 1'b0; bus.CCUOWR_CfgNip = '0; bus.CCUOWR_CfgBaseAddr = '0;
    bus.POLOWR_Ofm = '0; bus.POLOWR_OfmVld = 1'b0; bus.GLBOWR_WrRdy = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.OWRCCU_CfgRdy !== 1'b1) begin bad++; $display("FAIL rst_cfgrdy got=%b exp=1", bus.OWRCCU_CfgRdy); end
    total++; if (bus.OWRPOL_OfmRdy !== 1'b0) begin bad++; $display("FAIL rst_ofmrdy got=%b exp=0", bus.OWRPOL_OfmRdy); end
    total++; if (bus.OWRGLB_WrVld !== 1'b0) begin bad++; $display("FAIL rst_wrvld got=%b exp=0", bus.OWRGLB_WrVld); end
    total++; if (bus.OWRCCU_Done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.OWRCCU_Done); end
    total++; if (bus.OWRGLB_WrAddr !== 16'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus.OWRGLB_WrAddr); end
    total++; if (bus.OWRGLB_WrDat !== 256'h0) begin bad++; $display("FAIL rst_dat got=%h exp=0", bus.OWRGLB_WrDat); end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic check_stream(input string nm, input logic [15:0] base, input int npnt, input int vecOff);
    logic [15:0] expA;
    logic [255:0] expD;
    total++;
    if (wAddr.size() != 2 * npnt) begin bad++; $display("FAIL %s_count got=%0d exp=%0d", nm, wAddr.size(), 2 * npnt); end
    for (int i = 0; i < 2 * npnt && i < wAddr.size(); i++) begin
      expA = base + 16'(i);
      expD = (i % 2 == 0) ? vecs[(i / 2 + vecOff) % 8][255:0] : vecs[(i / 2 + vecOff) % 8][511:256];
      total++;
      if (wAddr[i] !== expA || wDat[i] !== expD) begin
        bad++; $display("FAIL %s_write%0d addr got=%h exp=%h dat got=%h exp=%h", nm, i, wAddr[i], expA, wDat[i], expD);
      end
    end
  endtask

  task automatic test_back_to_back();
    run(10'd3, 16'h0100, 3, 0, 4'hF, -1, 30);
    check_stream("b2b", 16'h0100, 3, 0);
    total++;
    if (wCyc.size() != 6 || wCyc[0] != 1 || wCyc[5] != 6) begin bad++; $display("FAIL b2b_timing got first=%0d last=%0d exp=1,6", wCyc[0], wCyc[wCyc.size()-1]); end
    total++;
    if (rdyCyc.size() != 3 || rdyCyc[0] != 0 || rdyCyc[1] != 2 || rdyCyc[2] != 4) begin bad++; $display("FAIL b2b_ofmrdy got n=%0d exp cycles 0,2,4", rdyCyc.size()); end
    total++; if (doneCyc != 7 || doneCnt != 1) begin bad++; $display("FAIL b2b_done got cyc=%0d n=%0d exp cyc=7 n=1", doneCyc, doneCnt); end
    total++; if (cfgRdyAfter !== 1'b1) begin bad++; $display("FAIL b2b_cfgrdy got=%b exp=1", cfgRdyAfter); end
  endtask

  task automatic test_stall();
    run(10'd3, 16'h0100, 3, 0, 4'b1001, -1, 40);
    check_stream("stall", 16'h0100, 3, 0);
    total++; if (stallBad != 0) begin bad++; $display("FAIL stall_hold got=%0d exp=0", stallBad); end
    total++; if (pendBad != 0) begin bad++; $display("FAIL stall_ofmrdy_pending got=%0d exp=0", pendBad); end
    total++;
    if (rdyCyc.size() != 3 || rdyCyc[0] != 0 || rdyCyc[1] != 4 || rdyCyc[2] != 8) begin bad++; $display("FAIL stall_ofmrdy got n=%0d exp cycles 0,4,8", rdyCyc.size()); end
    total++; if (doneCyc != 13 || doneCnt != 1) begin bad++; $display("FAIL stall_done got cyc=%0d n=%0d exp cyc=13 n=1", doneCyc, doneCnt); end
  endtask

  task automatic test_nip_zero();
    run(10'd0, 16'h0010, 1, 0, 4'hF, -1, 10);
    total++; if (wAddr.size() != 0 || rdyCyc.size() != 0) begin bad++; $display("FAIL nip0_activity got wr=%0d rdy=%0d exp=0,0", wAddr.size(), rdyCyc.size()); end
    total++; if (doneCyc != 0 || doneCnt != 1) begin bad++; $display("FAIL nip0_done got cyc=%0d n=%0d exp cyc=0 n=1", doneCyc, doneCnt); end
    total++; if (cfgRdyAfter !== 1'b1) begin bad++; $display("FAIL nip0_cfgrdy got=%b exp=1", cfgRdyAfter); end
  endtask

  task automatic test_wrap();
    logic [15:0] expA [4];
    expA[0] = 16'hFFFE; expA[1] = 16'hFFFF; expA[2] = 16'h0000; expA[3] = 16'h0001;
    run(10'd2, 16'hFFFE, 2, 2, 4'hF, -1, 20);
    total++; if (wAddr.size() != 4) begin bad++; $display("FAIL wrap_count got=%0d exp=4", wAddr.size()); end
    for (int i = 0; i < 4 && i < wAddr.size(); i++) begin
      total++; if (wAddr[i] !== expA[i]) begin bad++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, wAddr[i], expA[i]); end
    end
    total++; if (wDat.size() == 4 && wDat[3] !== vecs[3][511:256]) begin bad++; $display("FAIL wrap_dat3 got=%h exp=%h", wDat[3], vecs[3][511:256]); end
    total++; if (doneCnt != 1) begin bad++; $display("FAIL wrap_done got=%0d exp=1", doneCnt); end
  endtask

  task automatic test_soft_reset();
    run(10'd4, 16'h0040, 4, 0, 4'hF, 4, 15);
    total++;
    if (wAddr.size() != 4 || wCyc[3] != 4 || wAddr[3] !== 16'h0043) begin bad++; $display("FAIL srst_writes got n=%0d exp n=4 ending at cycle 4 addr 0043", wAddr.size()); end
    total++; if (doneCnt != 0) begin bad++; $display("FAIL srst_nodone got=%0d exp=0", doneCnt); end
    total++; if (lastCfgRdy !== 1'b1) begin bad++; $display("FAIL srst_cfgrdy got=%b exp=1", lastCfgRdy); end
    run(10'd1, 16'h0020, 1, 0, 4'hF, -1, 10);
    check_stream("srst_new", 16'h0020, 1, 0);
    total++; if (doneCnt != 1) begin bad++; $display("FAIL srst_new_done got=%0d exp=1", doneCnt); end
  endtask

  task automatic test_ignore();
    run(10'd1, 16'h0030, 2, 6, 4'hF, -1, 10);
    total++; if (wAddr.size() != 2) begin bad++; $display("FAIL ign_count got=%0d exp=2", wAddr.size()); end
    total++; if (rdyCyc.size() != 1 || rdyCyc[0] != 0) begin bad++; $display("FAIL ign_done_ofmrdy got n=%0d exp single at cycle 0", rdyCyc.size()); end
    @(posedge clk); #1;
    bus.POLOWR_OfmVld = 1'b1; bus.POLOWR_Ofm = vecs[5];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (bus.OWRPOL_OfmRdy !== 1'b0 || bus.OWRGLB_WrVld !== 1'b0) begin
        bad++; $display("FAIL ign_idle%0d got rdy=%b wvld=%b exp=0,0", i, bus.OWRPOL_OfmRdy, bus.OWRGLB_WrVld);
      end
    end
    run(10'd1, 16'h0031, 1, 5, 4'hF, -1, 10);
    check_stream("ign_after", 16'h0031, 1, 5);
    total++; if (rdyCyc.size() < 1 || rdyCyc[0] != 0) begin bad++; $display("FAIL ign_accept got n=%0d exp first at cycle 0", rdyCyc.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) vecs[i] = mkVec(i + 1);
    test_reset();
    test_back_to_back();
    test_stall();
    test_nip_zero();
    test_wrap();
    test_soft_reset();
    test_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
